wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back consumer of the MEM/WB pipeline register in the 8-bit five-stage CPU. It selects the write-back value (memory data or ALU result) and commits it to the 8×8 register file. It serves the decode stage's two operand reads with same-cycle write-back bypass. A per-register load scoreboard raises a decode stall on load-use hazards.

## Interface
Parameters:
- DATA_W, 8, register and datapath width
- NREG, 8, number of architectural registers (index width 3)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- WBregwr  in  1  write-back enable from MEM/WB
- WBregomem  in  1  1 = write readDATA, 0 = write ALUout
- readDATA  in  8  memory load data from MEM/WB
- ALUout  in  8  ALU result from MEM/WB
- writeREG  in  3  destination register from MEM/WB
- rs  in  3  decode read address A
- rt  in  3  decode read address B
- rsDATA  out  8  operand A, combinational
- rtDATA  out  8  operand B, combinational
- wbDATA  out  8  selected write-back value, combinational, for forwarding
- issue_load  in  1  decode issues a load this cycle
- issue_dest  in  3  destination of the issued load
- stall  out  1  load-use hazard; decode must hold

## Operation
- wbDATA = WBregomem ? readDATA : ALUout.
- Write: at the rising edge, if WBregwr and writeREG != 0, regs[writeREG] <= wbDATA.
- Register 0 always reads 0, and writes to it are dropped.
- Read: rsDATA = 0 if rs == 0.
  - Otherwise, if WBregwr and writeREG == rs, rsDATA = wbDATA (bypass).
  - Otherwise rsDATA = regs[rs].
  - rtDATA follows the same rule using rt.
- Scoreboard: pending[NREG-1:0], with bit 0 always 0.
  - Set pending[issue_dest] when issue_load is high, stall is low and issue_dest != 0.
  - Clear pending[writeREG] when WBregwr and WBregomem are both high.
  - Set and clear of the same register in one cycle: set wins, because the new load is younger.
  - issue_load while stall is high is ignored, since the load is not issued.
- Hazard check, for each x in {rs, rt}: hit_x = (x != 0) and pending[x], unless this cycle's write-back clears x. In that case the bypass supplies the value and hit_x = 0.
- stall = hit_rs or hit_rt. It is combinational and depends only on current state and inputs.
- Stall does not gate register writes or scoreboard clears.

## Timing
- Reset (rst high at an edge): all regs to 0 and all pending bits to 0.
  - After reset, rsDATA, rtDATA and wbDATA follow the combinational rules; with all inputs 0 they read 0.
  - After reset, stall = 0.
  - Reset overrides a simultaneous write-back and issue_load.
- Write latency: 1 edge to the array. Bypass makes the value visible to reads in the same cycle as the write-back.
- Scoreboard set is visible to stall from the cycle after issue. A clear takes effect immediately through the same-cycle exemption, then in state from the next cycle.
- A load issued at cycle t reaches WB at t+3.
  - A dependent read at t+1 or t+2 stalls.
  - A dependent read at t+3 does not stall and receives readDATA through the bypass.
- Reset in mid-operation discards all pending loads. The surrounding pipeline flushes on the same reset.

## Structure
- Shared package cpu_pkg holds DATA_W, REG_W = 3, NREG and the constant ZERO_REG = 3'd0. These are shared with the pipeline registers and the decode stage.
- One sub-module, load_scoreboard, owns the pending vector, set/clear priority and hazard compare.
  - Inputs: clk, rst, issue_load, issue_dest, clear_en, clear_reg, rs, rt.
  - Output: stall.
- The top level holds the register array, the write-back mux and the bypass muxes.

## Test plan
- Reset, then read all registers: rs = 1..7 -> rsDATA = 0 and stall = 0.
- WBregwr = 1, WBregomem = 0, ALUout = 8'h5A, writeREG = 3, rs = 3, same cycle -> rsDATA = 8'h5A via bypass. The next cycle, with WBregwr = 0 -> rsDATA = 8'h5A from the array.
- WBregwr = 1, writeREG = 0, ALUout = 8'hFF -> rs = 0 reads 0 both in the same cycle and later.
- WBregomem = 1, readDATA = 8'hC3, ALUout = 8'h11, writeREG = 5 -> wbDATA = 8'hC3 and regs[5] = 8'hC3.
- issue_load with issue_dest = 2 at t.
  - rt = 2 at t+1 and t+2 -> stall = 1.
  - At t+3, WBregwr = 1, WBregomem = 1, writeREG = 2, readDATA = 8'h77 -> stall = 0 and rtDATA = 8'h77.
- Simultaneous clear of r4 by write-back and new issue_load with dest 4 -> pending[4] stays set and rs = 4 stalls the next cycle. Separately, rst asserted while r4 is pending -> stall = 0 the next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Widths and constants shared by the pipeline registers, the decode stage
// and the write-back / register file block.
package cpu_pkg;
  localparam int DATA_W = 8;
  localparam int REG_W  = 3;
  localparam int NREG   = 8;

  localparam logic [REG_W-1:0] ZERO_REG = 3'd0;
endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB write-back, decode operand read and load-issue signals of the register file.
// Handshake: there is no valid/ready pair; WBregwr qualifies the write-back
// fields and issue_load qualifies issue_dest, each for the single cycle it is high.
interface wb_regfile_if;
  import cpu_pkg::*;

  logic              WBregwr;
  logic              WBregomem;
  logic [DATA_W-1:0] readDATA;
  logic [DATA_W-1:0] ALUout;
  logic [REG_W-1:0]  writeREG;
  logic [REG_W-1:0]  rs;
  logic [REG_W-1:0]  rt;
  logic [DATA_W-1:0] rsDATA;
  logic [DATA_W-1:0] rtDATA;
  logic [DATA_W-1:0] wbDATA;
  logic              issue_load;
  logic [REG_W-1:0]  issue_dest;
  logic              stall;

  modport master (
    output WBregwr, WBregomem, readDATA, ALUout, writeREG, rs, rt,
    output issue_load, issue_dest,
    input  rsDATA, rtDATA, wbDATA, stall
  );

  modport slave (
    input  WBregwr, WBregomem, readDATA, ALUout, writeREG, rs, rt,
    input  issue_load, issue_dest,
    output rsDATA, rtDATA, wbDATA, stall
  );
endinterface

// File: rtl/load_scoreboard.sv
// Per-register pending-load tracker; raises stall when decode reads a register
// whose load has been issued but has not yet reached write-back.
module load_scoreboard
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_load,
  input  logic [REG_W-1:0] issue_dest,
  input  logic             clear_en,
  input  logic [REG_W-1:0] clear_reg,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  output logic             stall
);
  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_pending_nxt;
  logic            w_set;
  logic            w_hit_rs;
  logic            w_hit_rt;

  // A load offered while decode is stalled is not issued, so it must not be recorded.
  assign w_set = issue_load && !stall && (issue_dest != ZERO_REG);

  always_comb begin
    w_pending_nxt = r_pending;
    if (clear_en) w_pending_nxt[clear_reg] = 1'b0;
    // Set after clear: the newly issued load is younger than the one retiring.
    if (w_set) w_pending_nxt[issue_dest] = 1'b1;
    w_pending_nxt[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_pending <= '0;
    else     r_pending <= w_pending_nxt;
  end

  // A register retiring this cycle is served by the bypass, so it is not a hazard.
  assign w_hit_rs = (rs != ZERO_REG) && r_pending[rs] && !(clear_en && (clear_reg == rs));
  assign w_hit_rt = (rt != ZERO_REG) && r_pending[rt] && !(clear_en && (clear_reg == rt));
  assign stall    = w_hit_rs || w_hit_rt;
endmodule

// File: rtl/wb_regfile.sv
// Write-back stage and 8x8 register file: selects the write-back value, commits
// it, and serves two decode reads with same-cycle bypass plus load-use stall.
module wb_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int NREG   = cpu_pkg::NREG
) (
  input logic         clk,
  input logic         rst,
  wb_regfile_if.slave bus
);
  logic [DATA_W-1:0] r_regs [NREG];
  logic [DATA_W-1:0] w_wb_data;
  logic              w_wr_en;
  logic              w_clear_en;

  assign w_wb_data  = bus.WBregomem ? bus.readDATA : bus.ALUout;
  assign w_wr_en    = bus.WBregwr && (bus.writeREG != ZERO_REG);
  assign w_clear_en = bus.WBregwr && bus.WBregomem;
  assign bus.wbDATA = w_wb_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[bus.writeREG] <= w_wb_data;
    end
  end

  always_comb begin
    bus.rsDATA = r_regs[bus.rs];
    if (bus.rs == ZERO_REG)                          bus.rsDATA = '0;
    else if (bus.WBregwr && bus.writeREG == bus.rs)  bus.rsDATA = w_wb_data;
  end

  always_comb begin
    bus.rtDATA = r_regs[bus.rt];
    if (bus.rt == ZERO_REG)                          bus.rtDATA = '0;
    else if (bus.WBregwr && bus.writeREG == bus.rt)  bus.rtDATA = w_wb_data;
  end

  load_scoreboard u_load_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .issue_load (bus.issue_load),
    .issue_dest (bus.issue_dest),
    .clear_en   (w_clear_en),
    .clear_reg  (bus.writeREG),
    .rs         (bus.rs),
    .rt         (bus.rt),
    .stall      (bus.stall)
  );
endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed write-back, bypass and load-use scenarios,
// then random ALU write-backs checked against a bench-side register model.
module tb_wb_regfile;
  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;
  logic [7:0] exp_q[$];
  logic [7:0] exp;
  logic [7:0] model_regs [8];

  wb_regfile_if bus ();

  wb_regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.WBregwr    = 1'b0;
    bus.WBregomem  = 1'b0;
    bus.readDATA   = 8'h00;
    bus.ALUout     = 8'h00;
    bus.writeREG   = 3'd0;
    bus.rs         = 3'd0;
    bus.rt         = 3'd0;
    bus.issue_load = 1'b0;
    bus.issue_dest = 3'd0;
  endtask

  // Drivers change inputs just after the falling edge; sampling is #1 later.
  task automatic next_cycle();
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    rst            = 1'b1;
    bus.WBregwr    = 1'b1;
    bus.writeREG   = 3'd3;
    bus.ALUout     = 8'hAA;
    bus.issue_load = 1'b1;
    bus.issue_dest = 3'd3;
    next_cycle();
    rst = 1'b0;
    for (int r = 1; r < 8; r++) begin
      next_cycle();
      bus.rs = r[2:0];
      bus.rt = r[2:0];
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);
      #1;
      exp = exp_q.pop_front(); tests_run++;
      if (bus.rsDATA !== exp) begin
        tests_failed++; $display("FAIL reset_rs r%0d: got %h expected %h", r, bus.rsDATA, exp);
      end
      exp = exp_q.pop_front(); tests_run++;
      if (bus.rtDATA !== exp) begin
        tests_failed++; $display("FAIL reset_rt r%0d: got %h expected %h", r, bus.rtDATA, exp);
      end
      exp = exp_q.pop_front(); tests_run++;
      if ({7'd0, bus.stall} !== exp) begin
        tests_failed++; $display("FAIL reset_stall r%0d: got %b expected %h", r, bus.stall, exp);
      end
    end
  endtask

  task automatic test_bypass();
    next_cycle();
    bus.WBregwr  = 1'b1;
    bus.ALUout   = 8'h5A;
    bus.writeREG = 3'd3;
    bus.rs       = 3'd3;
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h5A);
    #1;
    exp = exp_q.pop_front(); tests_run++;
    if (bus.rsDATA !== exp) begin
      tests_failed++; $display("FAIL bypass_rs: got %h expected %h", bus.rsDATA, exp);
    end
    exp = exp_q.pop_front(); tests_run++;
    if (bus.wbDATA !== exp) begin
      tests_failed++; $display("FAIL bypass_wbdata: got %h expected %h", bus.wbDATA, exp);
    end
    next_cycle();
    bus.rs = 3'd3;
    exp_q.push_back(8'h5A);
    #1;
    exp = exp_q.pop_front(); tests_run++;
    if (bus.rsDATA !== exp) begin
      tests_failed++; $display("FAIL array_rs: got %h expected %h", bus.rsDATA, exp);
    end
  endtask

  task automatic test_zero_reg();
    next_cycle();
    bus.WBregwr  = 1'b1;
    bus.ALUout   = 8'hFF;
    bus.writeREG = 3'd0;
    bus.rs       = 3'd0;
    bus.rt       = 3'd0;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    #1;
    exp = exp_q.pop_front(); tests_run++;
    if (bus.rsDATA !== exp) begin
      tests_failed++; $display("FAIL zero_rs_same: got %h expected %h", bus.rsDATA, exp);
    end
    exp = exp_q.pop_front(); tests_run++;
    if (bus.rtDATA !== exp) begin
      tests_failed++; $display("FAIL zero_rt_same: got %h expected %h", bus.rtDATA, exp);
    end
    next_cycle();
    bus.rs = 3'd0;
    bus.rt = 3'd3;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h5A);
    #1;
    exp = exp_q.pop_front(); tests_run++;
    if (bus.rsDATA !== exp) begin
      tests_failed++; $display("FAIL zero_rs_later: got %h expected %h", bus.rsDATA, exp);
    end
    exp = exp_q.pop_front(); tests_run++;
    if (bus.rtDATA !== exp) begin
      tests_failed++; $display("FAIL zero_keeps_r3: got %h expected %h", bus.rtDATA, exp);
    end
  endtask

  task automatic test_mem_select();
    next_cycle();
    bus.WBregwr   = 1'b1;
    bus.WBregomem = 1'b1;
    bus.readDATA  = 8'hC3;
    bus.ALUout    = 8'h11;
    bus.writeREG  = 3'd5;
    bus.rt        = 3'd5;
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'hC3);
    #1;
    exp = exp_q.pop_front(); tests_run++;
    if (bus.wbDATA !== exp) begin
      tests_failed++; $display("FAIL mem_wbdata: got %h expected %h", bus.wbDATA, exp);
    end
    exp = exp_q.pop_front(); tests_run++;
    if (bus.rtDATA !== exp) begin
      tests_failed++; $display("FAIL mem_rt_bypass: got %h expected %h", bus.rtDATA, exp);
    end
    next_cycle();
    bus.rs = 3'd5;
    exp_q.push_back(8'hC3);
    #1;
    exp = exp_q.pop_front(); tests_run++;
    if (bus.rsDATA !== exp) begin
      tests_failed++; $display("FAIL mem_array_r5: got %h expected %h", bus.rsDATA, exp);
    end
  endtask

  task automatic test_load_use();
    // t: issue load to r2
    next_cycle();
    bus.issue_load = 1'b1;
    bus.issue_dest = 3'd2;
    exp_q.push_back(8'h00);
    #1;
    exp = exp_q.pop_front(); tests_run++;
    if ({7'd0, bus.stall} !== exp) begin
      tests_failed++; $display("FAIL lu_issue_stall: got %b expected %h", bus.stall, exp);
    end
    // t+1 and t+2: dependent read stalls; a load offered while stalled is dropped
    for (int k = 1; k <= 2; k++) begin
      next_cycle();
      bus.rt         = 3'd2;
      bus.issue_load = (k == 1);
      bus.issue_dest = 3'd6;
      exp_q.push_back(8'h01);
      #1;
      exp = exp_q.pop_front(); tests_run++;
      if ({7'd0, bus.stall} !== exp) begin
        tests_failed++; $display("FAIL lu_stall_t%0d: got %b expected %h", k, bus.stall, exp);
      end
    end
    // t+3: load reaches write-back
    next_cycle();
    bus.WBregwr   = 1'b1;
    bus.WBregomem = 1'b1;
    bus.writeREG  = 3'd2;
    bus.readDATA  = 8'h77;
    bus.rt        = 3'd2;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h77);
    #1;
    exp = exp_q.pop_front(); tests_run++;
    if ({7'd0, bus.stall} !== exp) begin
      tests_failed++; $display("FAIL lu_wb_stall: got %b expected %h", bus.stall, exp);
    end
    exp = exp_q.pop_front(); tests_run++;
    if (bus.rtDATA !== exp) begin
      tests_failed++; $display("FAIL lu_wb_rt: got %h expected %h", bus.rtDATA, exp);
    end
    // t+4: pending cleared in state; r6 was never recorded
    next_cycle();
    bus.rt = 3'd2;
    bus.rs = 3'd6;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h77);
    #1;
    exp = exp_q.pop_front(); tests_run++;
    if ({7'd0, bus.stall} !== exp) begin
      tests_failed++; $display("FAIL lu_after_stall: got %b expected %h", bus.stall, exp);
    end
    exp = exp_q.pop_front(); tests_run++;
    if (bus.rtDATA !== exp) begin
      tests_failed++; $display("FAIL lu_after_rt: got %h expected %h", bus.rtDATA, exp);
    end
  endtask

  task automatic test_set_wins_and_reset_flush();
    next_cycle();
    bus.issue_load = 1'b1;
    bus.issue_dest = 3'd4;
    next_cycle();
    bus.WBregwr    = 1'b1;
    bus.WBregomem  = 1'b1;
    bus.writeREG   = 3'd4;
    bus.readDATA   = 8'h44;
    bus.issue_load = 1'b1;
    bus.issue_dest = 3'd4;
    exp_q.push_back(8'h00);
    #1;
    exp = exp_q.pop_front(); tests_run++;
    if ({7'd0, bus.stall} !== exp) begin
      tests_failed++; $display("FAIL setwins_same_stall: got %b expected %h", bus.stall, exp);
    end
    next_cycle();
    bus.rs = 3'd4;
    exp_q.push_back(8'h01);
    #1;
    exp = exp_q.pop_front(); tests_run++;
    if ({7'd0, bus.stall} !== exp) begin
      tests_failed++; $display("FAIL setwins_next_stall: got %b expected %h", bus.stall, exp);
    end
    // Reset while r4 is pending
    next_cycle();
    rst    = 1'b1;
    bus.rs = 3'd4;
    next_cycle();
    rst    = 1'b0;
    bus.rs = 3'd4;
    bus.rt = 3'd5;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    #1;
    exp = exp_q.pop_front(); tests_run++;
    if ({7'd0, bus.stall} !== exp) begin
      tests_failed++; $display("FAIL flush_stall: got %b expected %h", bus.stall, exp);
    end
    exp = exp_q.pop_front(); tests_run++;
    if (bus.rsDATA !== exp) begin
      tests_failed++; $display("FAIL flush_r4: got %h expected %h", bus.rsDATA, exp);
    end
    exp = exp_q.pop_front(); tests_run++;
    if (bus.rtDATA !== exp) begin
      tests_failed++; $display("FAIL flush_r5: got %h expected %h", bus.rtDATA, exp);
    end
  endtask

  task automatic test_random_alu();
    logic [7:0] d;
    logic [2:0] w;
    logic       we;
    logic [2:0] a;
    logic [2:0] b;
    for (int r = 0; r < 8; r++) model_regs[r] = 8'h00;
    for (int n = 0; n < 40; n++) begin
      d  = 8'($urandom_range(0, 255));
      w  = 3'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      a  = 3'($urandom_range(0, 7));
      b  = 3'($urandom_range(0, 7));
      next_cycle();
      bus.WBregwr  = we;
      bus.ALUout   = d;
      bus.writeREG = w;
      bus.rs       = a;
      bus.rt       = b;
      exp_q.push_back((a == 3'd0) ? 8'h00 : (we && w == a) ? d : model_regs[a]);
      exp_q.push_back((b == 3'd0) ? 8'h00 : (we && w == b) ? d : model_regs[b]);
      if (we && w != 3'd0) model_regs[w] = d;
      #1;
      exp = exp_q.pop_front(); tests_run++;
      if (bus.rsDATA !== exp) begin
        tests_failed++; $display("FAIL rand_rs n%0d: got %h expected %h", n, bus.rsDATA, exp);
      end
      exp = exp_q.pop_front(); tests_run++;
      if (bus.rtDATA !== exp) begin
        tests_failed++; $display("FAIL rand_rt n%0d: got %h expected %h", n, bus.rtDATA, exp);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    test_reset();
    test_bypass();
    test_zero_reg();
    test_mem_select();
    test_load_use();
    test_set_wins_and_reset_flush();
    test_random_alu();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
